// File: rtl/ref_mem_pkg.sv
// Shared constants and types for the reference sequential memory.
// Holds the read-during-write policy codes and the controller state type.
package ref_mem_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/ref_seq_mem_if.sv
// One memory access port: a read request channel, a byte-enabled write channel and the read response.
// The memory is the slave; whatever issues requests is the master.
interface ref_seq_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   we;
    logic [ADDR_WIDTH-1:0] addw;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  err;

    modport master (
        output re, addr, we, addw, din,
        input  dout, dout_valid, err
    );

    modport slave (
        input  re, addr, we, addw, din,
        output dout, dout_valid, err
    );
endinterface

// File: rtl/ref_mem_out_pipe.sv
// Read-response register chain of 1 or 2 stages carrying data, valid and error.
// Data only advances alongside a valid, so the output holds the last response.
module ref_mem_out_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    err_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= err_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                err_q[s]   <= err_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign err_o   = err_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];
endmodule

// File: rtl/ref_seq_mem.sv
// Dual-port byte-enabled reference memory that zero-fills itself after reset.
// Port A wins on lanes written by both ports; cross-port reads always see old data.
module ref_seq_mem
    import ref_mem_pkg::*;
#(
    parameter int MEM_SIZE     = 4096,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RDW_MODE     = RDW_READ_FIRST,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    ref_seq_mem_if.slave  port_a,
    ref_seq_mem_if.slave  port_b
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH     = MEM_SIZE / BE_WIDTH;
    localparam int IDX_SHIFT = $clog2(BE_WIDTH);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_e            state_q, state_d;
    logic [IDX_W-1:0]      clrCnt_q, clrCnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  re     [2];
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic [BE_WIDTH-1:0]   we     [2];
    logic [ADDR_WIDTH-1:0] addw   [2];
    logic [DATA_WIDTH-1:0] din    [2];
    logic [ADDR_WIDTH-1:0] rdFull [2];
    logic [ADDR_WIDTH-1:0] wrFull [2];
    logic                  rdIn   [2];
    logic                  wrIn   [2];
    logic [IDX_W-1:0]      rdIdx  [2];
    logic [IDX_W-1:0]      wrIdx  [2];
    logic                  wrOk   [2];
    logic                  validIn[2];
    logic                  errIn  [2];
    logic [DATA_WIDTH-1:0] rdData [2];
    logic                  active;

    assign re[0]   = port_a.re;
    assign addr[0] = port_a.addr;
    assign we[0]   = port_a.we;
    assign addw[0] = port_a.addw;
    assign din[0]  = port_a.din;
    assign re[1]   = port_b.re;
    assign addr[1] = port_b.addr;
    assign we[1]   = port_b.we;
    assign addw[1] = port_b.addw;
    assign din[1]  = port_b.din;

    assign active    = (state_q == READY);
    assign init_busy = (state_q == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        if (state_q == CLEAR) begin
            clrCnt_d = clrCnt_q + 1'b1;
            if (clrCnt_q == IDX_W'(DEPTH - 1)) begin
                state_d  = READY;
                clrCnt_d = '0;
            end
        end
    end

    // Range checks use the full shifted address so out-of-range words never alias onto low words.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdFull[p]  = addr[p] >> IDX_SHIFT;
            wrFull[p]  = addw[p] >> IDX_SHIFT;
            rdIn[p]    = rdFull[p] < ADDR_WIDTH'(DEPTH);
            wrIn[p]    = wrFull[p] < ADDR_WIDTH'(DEPTH);
            rdIdx[p]   = rdFull[p][IDX_W-1:0];
            wrIdx[p]   = wrFull[p][IDX_W-1:0];
            wrOk[p]    = active && (|we[p]) && wrIn[p];
            validIn[p] = active && re[p];
            errIn[p]   = active && ((re[p] && !rdIn[p]) || ((|we[p]) && !wrIn[p]));
            rdData[p]  = mem_q[rdIdx[p]];
            if (RDW_MODE == RDW_WRITE_FIRST && wrOk[p] && wrIdx[p] == rdIdx[p]) begin
                for (int l = 0; l < BE_WIDTH; l++) begin
                    if (we[p][l]) begin
                        rdData[p][8*l +: 8] = din[p][8*l +: 8];
                    end
                end
            end
            if (!rdIn[p]) begin
                rdData[p] = '0;
            end
        end
    end

    // Port B is applied first so port A's lanes override on a shared word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clrCnt_q] <= '0;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    if (wrOk[p]) begin
                        for (int l = 0; l < BE_WIDTH; l++) begin
                            if (we[p][l]) begin
                                mem_q[wrIdx[p]][8*l +: 8] <= din[p][8*l +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    ref_mem_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .valid_i (validIn[0]),
        .err_i   (errIn[0]),
        .data_i  (rdData[0]),
        .valid_o (port_a.dout_valid),
        .err_o   (port_a.err),
        .data_o  (port_a.dout)
    );

    ref_mem_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .valid_i (validIn[1]),
        .err_i   (errIn[1]),
        .data_i  (rdData[1]),
        .valid_o (port_b.dout_valid),
        .err_o   (port_b.err),
        .data_o  (port_b.dout)
    );
endmodule
